// File: rtl/input_tile_fetcher.sv
// Input tile fetcher: turns block-address requests into dual-port buffer reads
// and queues the returned Winograd tile pairs in a small output FIFO.
module input_tile_fetcher #(
    parameter int TILE_W     = 288,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          input_request_i,
    input  logic [7:0]                    input_addr_1_i,
    input  logic [7:0]                    input_addr_2_i,
    input  logic [3:0]                    current_id_i,
    input  logic [7:0]                    block_cnt_i,
    input  logic                          size_type_i,
    output logic                          mem_ren1_o,
    output logic                          mem_ren2_o,
    output logic [ADDR_W-1:0]             mem_addr1_o,
    output logic [ADDR_W-1:0]             mem_addr2_o,
    input  logic [TILE_W-1:0]             mem_rdata1_i,
    input  logic [TILE_W-1:0]             mem_rdata2_i,
    output logic                          tile_valid_o,
    input  logic                          tile_ready_i,
    output logic [TILE_W-1:0]             tile1_o,
    output logic [TILE_W-1:0]             tile2_o,
    output logic                          tile2_en_o,
    output logic [3:0]                    tile_id_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // 4x4 tiles occupy only the low 16 elements (128 bits) of the tile word.
    localparam logic [TILE_W-1:0] MASK_4X4 = {{(TILE_W-128){1'b0}}, {128{1'b1}}};

    typedef struct packed {
        logic [TILE_W-1:0] tile1;
        logic [TILE_W-1:0] tile2;
        logic              tile2_en;
        logic [3:0]        id;
    } entry_t;

    // Stage 1 (issue) and stage 2 (return) sideband registers.
    logic       s1_valid, s1_v2, s1_size;
    logic [3:0] s1_id;
    logic       s2_valid, s2_v2, s2_size;
    logic [3:0] s2_id;

    logic [12:0] base;
    assign base = 13'(current_id_i) * 13'(block_cnt_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_v2       <= 1'b0;
            s1_size     <= 1'b0;
            s1_id       <= '0;
            s2_valid    <= 1'b0;
            s2_v2       <= 1'b0;
            s2_size     <= 1'b0;
            s2_id       <= '0;
            mem_ren1_o  <= 1'b0;
            mem_ren2_o  <= 1'b0;
            mem_addr1_o <= '0;
            mem_addr2_o <= '0;
        end else begin
            s1_valid   <= input_request_i;
            mem_ren1_o <= input_request_i;
            mem_ren2_o <= input_request_i && (input_addr_2_i != 8'hFF);
            if (input_request_i) begin
                s1_v2       <= (input_addr_2_i != 8'hFF);
                s1_size     <= size_type_i;
                s1_id       <= current_id_i;
                mem_addr1_o <= ADDR_W'(base + 13'(input_addr_1_i));
                mem_addr2_o <= ADDR_W'(base + 13'(input_addr_2_i));
            end
            s2_valid <= s1_valid;
            s2_v2    <= s1_v2;
            s2_size  <= s1_size;
            s2_id    <= s1_id;
        end
    end

    entry_t entry_in;
    always_comb begin
        entry_in.tile1    = s2_size ? mem_rdata1_i : (mem_rdata1_i & MASK_4X4);
        entry_in.tile2    = s2_v2 ? (s2_size ? mem_rdata2_i : (mem_rdata2_i & MASK_4X4)) : '0;
        entry_in.tile2_en = s2_v2;
        entry_in.id       = s2_id;
    end

    entry_t             store [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, push, pop, push_ok;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign push    = s2_valid;
    assign pop     = tile_valid_o && tile_ready_i;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= entry_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow_o <= 1'b1;
        end
    end

    entry_t head;
    assign head         = store[rd_ptr];
    assign tile_valid_o = (count != '0);
    assign tile1_o      = tile_valid_o ? head.tile1 : '0;
    assign tile2_o      = tile_valid_o ? head.tile2 : '0;
    assign tile2_en_o   = tile_valid_o ? head.tile2_en : 1'b0;
    assign tile_id_o    = tile_valid_o ? head.id : 4'd0;
    assign fifo_count_o = count;
endmodule

// File: doc/input_tile_fetcher.md
# input_tile_fetcher

Responder for the main controller's input-request stream. Each request names two block addresses for one input channel; the block reads both Winograd input tiles from the dual-port on-chip input buffer and queues them in a 4-entry output FIFO. The FIFO feeds the transform/PE array with a valid/ready handshake. The request side has no backpressure, so the FIFO absorbs stalls and overflow is flagged rather than prevented.

## Interface
Parameters:
- TILE_W, 288, bits per tile word (36 elements × 8 bit, 6x6 tile)
- ADDR_W, 12, input-buffer address width
- FIFO_DEPTH, 4, output FIFO entries (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- input_request_i  in  1  request valid, one request per high cycle
- input_addr_1_i  in  8  first block address
- input_addr_2_i  in  8  second block address; 8'hFF = no second tile
- current_id_i  in  4  input-channel index of the request
- block_cnt_i  in  8  blocks per channel (quasi-static)
- size_type_i  in  1  0 = 4x4 tile (F(2,3)), 1 = 6x6 tile (F(4,3)); quasi-static
- mem_ren1_o / mem_ren2_o  out  1  read enables, ports 1/2
- mem_addr1_o / mem_addr2_o  out  ADDR_W  read addresses
- mem_rdata1_i / mem_rdata2_i  in  TILE_W  read data, valid one cycle after ren
- tile_valid_o  out  1  FIFO head valid
- tile_ready_i  in  1  consumer accepts head
- tile1_o / tile2_o  out  TILE_W  head tiles
- tile2_en_o  out  1  tile2_o is meaningful
- tile_id_o  out  4  channel index of head
- fifo_count_o  out  3  occupancy 0..4
- overflow_o  out  1  sticky: a tile pair was dropped

## Operation
- S0 capture: when input_request_i=1, register addr1, addr2, id, size_type, and v2 = (addr2 != 8'hFF).
- S1 issue: drive mem_addrK_o = (id × block_cnt_i + addrK) mod 2^ADDR_W. Compute the product and sum at 13 bits, then truncate. mem_ren1_o=1; mem_ren2_o=v2. When no request occupies S1, both ren=0 and addresses hold their last value.
- S2 return: mem data arrives. Apply the mask: when size_type=0, bits [TILE_W-1:128] are forced to 0 on both tiles. When v2=0, tile2 is zeroed. Push {tile1, tile2, v2, id} into the FIFO.
- Push and pop: pop when tile_valid_o && tile_ready_i. A push and a pop in the same cycle are both performed, including when the FIFO is full (count unchanged).
- Overflow: a push into a full FIFO with no pop is dropped, and overflow_o sets and stays 1 until reset. The pipeline never stalls.
- Order: FIFO output order equals request order.
- Head outputs: tile_valid_o = (count != 0). When the FIFO is empty, tile1_o, tile2_o, tile2_en_o and tile_id_o are 0.
- Wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: all outputs 0, FIFO empty, pipeline stages invalid, overflow_o=0. Asserting reset mid-operation discards in-flight requests and FIFO contents immediately.
- Request high in cycle N:
  - ren/addr driven in N+1.
  - rdata sampled at the end of N+2.
  - tile_valid_o=1 in N+3 if the FIFO was empty. Latency is 3 cycles.
- Throughput: one request per cycle sustained while tile_ready_i=1.
- The head is held stable while tile_valid_o=1 and tile_ready_i=0.
- fifo_count_o and overflow_o update on the same edge as the push/pop.

## Test plan
- Single request, addr1=0, addr2=1, id=2, block_cnt=4, size_type=1, ready=1:
  - mem_addr1_o=8, mem_addr2_o=9, both ren=1 at N+1.
  - tile_valid_o=1 at N+3 for one cycle with tile_id_o=2, tile2_en_o=1.
- Request addr1=7, addr2=8'hFF:
  - mem_ren2_o=0.
  - Head shows tile2_en_o=0 and tile2_o=0.
- size_type=0 with memory returning all-ones: tile1_o bits [287:128]=0 and bits [127:0]=all ones.
- Back-to-back requests for addresses 0..9 with ready=0:
  - fifo_count_o saturates at 4 and overflow_o=1 after the 5th push.
  - After ready=1, outputs drain as the pairs from the first four requests (addresses 0..7) in order.
- Full FIFO with ready=1 and a new push in the same cycle: count stays 4, overflow_o stays 0, no data lost.
- Reset asserted 2 cycles after a request: no tile_valid_o ever appears and all outputs read 0.
